// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan byte decoder: pops bytes from the receiver FIFO, tracks the held key and counts presses.
// Optional macro PS2_KEY_ASCII_EN builds the ASCII lookup; without it key_ascii stays 0.
module ps2_key_decoder #(
   parameter int CNT_W   = 8,
   parameter int POP_GAP = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             kb_ready,
   input  logic [7:0]       kb_data,
   output logic             kb_nextdata_n,
   output logic             key_valid,
   output logic             key_ext,
   output logic [7:0]       key_code,
   output logic [7:0]       key_ascii,
   output logic [CNT_W-1:0] key_count,
   output logic [15:0]      seg_data
);

   localparam logic [7:0] BYTE_EXT = 8'hE0;
   localparam logic [7:0] BYTE_BRK = 8'hF0;
   localparam logic [3:0] GAP_LOAD = 4'(POP_GAP - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_POP  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t     state_r;
   logic [3:0] gap_r;
   logic       ext_pend_r;
   logic       brk_pend_r;
   logic       same_key_s;

`ifdef PS2_KEY_ASCII_EN
   function automatic logic [7:0] ascii_of(input logic [7:0] code);
      case (code)
         8'h1C: ascii_of = 8'h61;  8'h32: ascii_of = 8'h62;  8'h21: ascii_of = 8'h63;
         8'h23: ascii_of = 8'h64;  8'h24: ascii_of = 8'h65;  8'h2B: ascii_of = 8'h66;
         8'h34: ascii_of = 8'h67;  8'h33: ascii_of = 8'h68;  8'h43: ascii_of = 8'h69;
         8'h3B: ascii_of = 8'h6A;  8'h42: ascii_of = 8'h6B;  8'h4B: ascii_of = 8'h6C;
         8'h3A: ascii_of = 8'h6D;  8'h31: ascii_of = 8'h6E;  8'h44: ascii_of = 8'h6F;
         8'h4D: ascii_of = 8'h70;  8'h15: ascii_of = 8'h71;  8'h2D: ascii_of = 8'h72;
         8'h1B: ascii_of = 8'h73;  8'h2C: ascii_of = 8'h74;  8'h3C: ascii_of = 8'h75;
         8'h2A: ascii_of = 8'h76;  8'h1D: ascii_of = 8'h77;  8'h22: ascii_of = 8'h78;
         8'h35: ascii_of = 8'h79;  8'h1A: ascii_of = 8'h7A;
         8'h45: ascii_of = 8'h30;  8'h16: ascii_of = 8'h31;  8'h1E: ascii_of = 8'h32;
         8'h26: ascii_of = 8'h33;  8'h25: ascii_of = 8'h34;  8'h2E: ascii_of = 8'h35;
         8'h36: ascii_of = 8'h36;  8'h3D: ascii_of = 8'h37;  8'h3E: ascii_of = 8'h38;
         8'h46: ascii_of = 8'h39;  8'h29: ascii_of = 8'h20;
         default: ascii_of = 8'h00;
      endcase
   endfunction
`endif

   assign same_key_s = key_valid && (kb_data == key_code) && (ext_pend_r == key_ext);
   assign seg_data   = {key_ascii, key_code};

   // Pop handshake sequencing and byte decode; the held-key outputs change on the capture edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= S_IDLE;
         gap_r         <= 4'd0;
         ext_pend_r    <= 1'b0;
         brk_pend_r    <= 1'b0;
         kb_nextdata_n <= 1'b1;
         key_valid     <= 1'b0;
         key_ext       <= 1'b0;
         key_code      <= 8'h00;
         key_ascii     <= 8'h00;
         key_count     <= '0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (kb_ready) begin
                  kb_nextdata_n <= 1'b0;
                  state_r       <= S_POP;
                  if (kb_data == BYTE_EXT) begin
                     ext_pend_r <= 1'b1;
                  end else if (kb_data == BYTE_BRK) begin
                     brk_pend_r <= 1'b1;
                  end else begin
                     ext_pend_r <= 1'b0;
                     brk_pend_r <= 1'b0;
                     if (brk_pend_r) begin
                        if (same_key_s) begin
                           key_valid <= 1'b0;
                        end
                     end else if (!same_key_s) begin
                        key_code  <= kb_data;
                        key_ext   <= ext_pend_r;
                        key_valid <= 1'b1;
                        key_count <= key_count + CNT_W'(1);
`ifdef PS2_KEY_ASCII_EN
                        key_ascii <= ext_pend_r ? 8'h00 : ascii_of(kb_data);
`endif
                     end
                  end
               end
            end
            S_POP: begin
               kb_nextdata_n <= 1'b1;
               gap_r         <= GAP_LOAD;
               state_r       <= S_GAP;
            end
            S_GAP: begin
               if (gap_r == 4'd0) begin
                  state_r <= S_IDLE;
               end else begin
                  gap_r <= gap_r - 4'd1;
               end
            end
            default: begin
               state_r       <= S_IDLE;
               kb_nextdata_n <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomised and directed bench for ps2_key_decoder against a held-key reference model.
module tb_ps2_key_decoder;

   localparam int CNT_W   = 8;
   localparam int POP_GAP = 2;
`ifdef PS2_KEY_ASCII_EN
   localparam bit ASCII_ON = 1'b1;
`else
   localparam bit ASCII_ON = 1'b0;
`endif

   localparam logic [7:0] LETTER_CODE [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B,
      8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   localparam logic [7:0] DIGIT_CODE [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
      8'h36, 8'h3D, 8'h3E, 8'h46};
   localparam logic [7:0] POOL [8] = '{8'h1C, 8'h32, 8'h75, 8'h29, 8'h45, 8'h1A, 8'h6B, 8'h46};

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             kb_ready = 1'b0;
   logic [7:0]       kb_data = 8'h00;
   logic             kb_nextdata_n;
   logic             key_valid;
   logic             key_ext;
   logic [7:0]       key_code;
   logic [7:0]       key_ascii;
   logic [CNT_W-1:0] key_count;
   logic [15:0]      seg_data;
   logic             rst_at_edge = 1'b1;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int rdy_cyc = -100;
   int vld_cyc = -200;
   logic prev_valid = 1'b0;
   logic [7:0] fifo[$];
   int pop_cyc[$];

   // reference model state: the held key and prefix flags, plus cycles until ready is looked at again
   logic       m_valid, m_ext, m_epend, m_bpend, m_nd;
   logic [7:0] m_code;
   int         m_count;
   int         m_block;

   ps2_key_decoder #(.CNT_W(CNT_W), .POP_GAP(POP_GAP)) dut (
      .clk(clk), .rst(rst), .kb_ready(kb_ready), .kb_data(kb_data),
      .kb_nextdata_n(kb_nextdata_n), .key_valid(key_valid), .key_ext(key_ext),
      .key_code(key_code), .key_ascii(key_ascii), .key_count(key_count), .seg_data(seg_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rst_at_edge <= rst;

   function automatic logic [7:0] ascii_ref(input logic [7:0] c, input logic e);
      if (!ASCII_ON || e) return 8'h00;
      for (int i = 0; i < 26; i++) if (LETTER_CODE[i] == c) return 8'h61 + 8'(i);
      for (int i = 0; i < 10; i++) if (DIGIT_CODE[i] == c) return 8'h30 + 8'(i);
      if (c == 8'h29) return 8'h20;
      return 8'h00;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0; m_ext = 1'b0; m_epend = 1'b0; m_bpend = 1'b0; m_nd = 1'b1;
      m_code = 8'h00; m_count = 0; m_block = 0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      logic same;
      if (b == 8'hE0) m_epend = 1'b1;
      else if (b == 8'hF0) m_bpend = 1'b1;
      else begin
         same = m_valid && (b == m_code) && (m_epend == m_ext);
         if (m_bpend) begin
            if (same) m_valid = 1'b0;
         end else if (!same) begin
            m_code = b; m_ext = m_epend; m_valid = 1'b1;
            m_count = (m_count + 1) % (1 << CNT_W);
         end
         m_epend = 1'b0; m_bpend = 1'b0;
      end
   endtask

   task automatic model_step();
      if (m_block > 0) begin
         m_block--; m_nd = 1'b1;
      end else if (kb_ready) begin
         model_byte(kb_data); m_nd = 1'b0; m_block = POP_GAP + 1;
      end else begin
         m_nd = 1'b1;
      end
   endtask

   // Model update for the edge just passed, per-cycle compare, FIFO pop and input drive.
   always @(negedge clk) begin
      logic nr;
      cyc++;
      if (rst || rst_at_edge) model_reset();
      else model_step();
      check("nextdata_n", 32'(kb_nextdata_n), 32'(m_nd));
      check("key_valid", 32'(key_valid), 32'(m_valid));
      check("key_ext", 32'(key_ext), 32'(m_ext));
      check("key_code", 32'(key_code), 32'(m_code));
      check("key_ascii", 32'(key_ascii), 32'(ascii_ref(m_code, m_ext)));
      check("key_count", 32'(key_count), 32'(m_count));
      check("seg_data", 32'(seg_data), 32'({ascii_ref(m_code, m_ext), m_code}));
      if (!rst && kb_nextdata_n === 1'b0 && fifo.size() > 0) begin
         void'(fifo.pop_front());
         pop_cyc.push_back(cyc);
      end
      if (!prev_valid && key_valid === 1'b1) vld_cyc = cyc;
      prev_valid = key_valid;
      nr = (fifo.size() > 0) && !rst;
      if (nr && !kb_ready) rdy_cyc = cyc;
      kb_ready = nr;
      kb_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
   end

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic do_reset();
      tick(); rst = 1'b1; fifo.delete();
      tick(); tick(); rst = 1'b0;
      tick();
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((fifo.size() != 0 || m_block != 0 || kb_ready) && t < 3000) begin
         tick(); t++;
      end
      if (t >= 3000) begin
         n_cmp++; n_bad++;
         $display("FAIL idle_timeout: fifo still holds %0d bytes", fifo.size());
      end
      tick();
   endtask

   task automatic send(input logic [7:0] b);
      fifo.push_back(b);
   endtask

   task automatic expect_key(input string tag, input logic v, input logic e, input logic [7:0] c,
                             input int cnt);
      check({tag, "_valid"}, 32'(key_valid), 32'(v));
      check({tag, "_ext"}, 32'(key_ext), 32'(e));
      check({tag, "_code"}, 32'(key_code), 32'(c));
      check({tag, "_count"}, 32'(key_count), 32'(cnt));
   endtask

   initial begin
      logic [7:0] a61, a62;
      a61 = ASCII_ON ? 8'h61 : 8'h00;
      a62 = ASCII_ON ? 8'h62 : 8'h00;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      expect_key("reset", 1'b0, 1'b0, 8'h00, 0);
      check("reset_nextdata", 32'(kb_nextdata_n), 32'd1);

      pop_cyc.delete();
      send(8'h1C); wait_idle();
      expect_key("first", 1'b1, 1'b0, 8'h1C, 1);
      check("first_seg", 32'(seg_data), 32'({a61, 8'h1C}));
      check("first_latency", 32'(vld_cyc - rdy_cyc), 32'd1);
      check("first_pops", 32'(pop_cyc.size()), 32'd1);

      send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); wait_idle();
      expect_key("typematic", 1'b0, 1'b0, 8'h1C, 1);

      send(8'hE0); send(8'h75); wait_idle();
      expect_key("ext_make", 1'b1, 1'b1, 8'h75, 2);
      check("ext_ascii", 32'(key_ascii), 32'd0);
      send(8'hE0); send(8'hF0); send(8'h75); wait_idle();
      expect_key("ext_break", 1'b0, 1'b1, 8'h75, 2);
      send(8'hE0); send(8'h75); send(8'hF0); send(8'hE0); send(8'h75); wait_idle();
      expect_key("ext_break_swap", 1'b0, 1'b1, 8'h75, 3);

      do_reset();
      send(8'h1C); send(8'hF0); send(8'h32); wait_idle();
      expect_key("mismatch_break", 1'b1, 1'b0, 8'h1C, 1);
      send(8'h32); wait_idle();
      expect_key("second_key", 1'b1, 1'b0, 8'h32, 2);
      check("second_ascii", 32'(key_ascii), 32'(a62));

      pop_cyc.delete();
      for (int i = 0; i < 10; i++) send((i % 2 == 0) ? 8'h1C : 8'h32);
      wait_idle();
      check("burst_pops", 32'(pop_cyc.size()), 32'd10);
      for (int i = 1; i < pop_cyc.size(); i++)
         check("burst_spacing", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'(2 + POP_GAP));
      expect_key("burst", 1'b1, 1'b0, 8'h32, 12);

      do_reset();
      for (int i = 0; i < 256; i++) send((i % 2 == 0) ? 8'h1C : 8'h32);
      wait_idle();
      expect_key("wrap", 1'b1, 1'b0, 8'h32, 0);

      do_reset();
      send(8'hE0); wait_idle();
      do_reset();
      send(8'h1C); wait_idle();
      expect_key("reset_prefix", 1'b1, 1'b0, 8'h1C, 1);

      for (int i = 0; i < 600; i++) begin
         int t = 0;
         int r;
         while (fifo.size() > 6 && t < 1000) begin tick(); t++; end
         r = $urandom_range(0, 9);
         if (r == 0) send(8'hE0);
         else if (r == 1) send(8'hF0);
         else if (r == 8) send(8'($urandom_range(0, 255)));
         else send(POOL[$urandom_range(0, 7)]);
         if (i == 300) do_reset();
         repeat ($urandom_range(0, 5)) tick();
      end
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      n_bad++;
      $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog expired");
   end

endmodule
